// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter
//   Two-requester round-robin arbiter in front of a single-port SRAM.
//   Each access is IDLE -> ACCESS -> DONE, one cycle per state, so the
//   best sustained rate is one access every three cycles.
//
// Ports
//   clk        in   clock, rising edge
//   reset_p    in   synchronous active-high reset
//   req        in   [1:0] access request per requester
//   we         in   [1:0] write select per requester (1 = write)
//   addr0/1    in   [AW-1:0] requester address
//   wdata0/1   in   [DW-1:0] requester write data
//   gnt        out  [1:0] one-hot grant, high during ACCESS
//   ack        out  [1:0] one-hot completion, high during DONE
//   rdata      out  [DW-1:0] read data, valid while ack is high for a read
//   busy       out  high whenever the arbiter is not IDLE
//   mem_wr_en  out  SRAM write enable
//   mem_rd_en  out  SRAM read enable / bus drive enable
//   mem_addr   out  [AW-1:0] SRAM address
//   mem_wdata  out  [DW-1:0] SRAM write data
//   mem_rdata  in   [DW-1:0] SRAM read data, combinational from mem_addr
module sram_rr_arbiter #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_p,
    input  logic [1:0]    req,
    input  logic [1:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    gnt,
    output logic [1:0]    ack,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_wr_en,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          win_q, win_d;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          last_q;     // requester that completed most recently
    logic [DW-1:0] rdata_q;

    // Tie goes to whoever did not win last time; a lone request always wins.
    assign win_d = (req[0] & req[1]) ? ~last_q : req[1];

    // State register
    always_ff @(posedge clk) begin
        if (reset_p) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = (req != 2'b00) ? ACCESS : IDLE;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, read capture and round-robin history.
    // The request is captured at the arbitration edge so later input
    // changes cannot disturb the access in flight.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            if (state_q == IDLE && req != 2'b00) begin
                win_q   <= win_d;
                we_q    <= we[win_d];
                addr_q  <= win_d ? addr1  : addr0;
                wdata_q <= win_d ? wdata1 : wdata0;
            end
            if (state_q == ACCESS && !we_q)
                rdata_q <= mem_rdata;
            if (state_q == DONE)
                last_q <= win_q;
        end
    end

    // Outputs: the SRAM bus is only driven during ACCESS, and address/data
    // are gated so the bus reads as zero whenever the arbiter is idle.
    always_comb begin
        gnt       = 2'b00;
        ack       = 2'b00;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (state_q != IDLE);
        rdata     = rdata_q;
        case (state_q)
            ACCESS: begin
                gnt       = win_q ? 2'b10 : 2'b01;
                mem_wr_en = we_q;
                mem_rd_en = ~we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            DONE: begin
                ack = win_q ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a behavioural SRAM attached.
module tb_sram_rr_arbiter;
    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_p;
    logic [1:0]    req, we;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    gnt, ack;
    logic [DW-1:0] rdata;
    logic          busy, mem_wr_en, mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int errors = 0;
    int checks = 0;

    sram_rr_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset_p(reset_p), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem_rd_en ? mem[mem_addr] : '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_p = 1'b1;
        tick(); tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({mem_wr_en, mem_rd_en} !== 2'b00) begin errors++; $display("FAIL reset_en: got %b want 00", {mem_wr_en, mem_rd_en}); end
        checks++; if (mem_addr !== 10'h000) begin errors++; $display("FAIL reset_addr: got %h want 000", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h want 00", mem_wdata); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        reset_p = 1'b0;
    endtask

    task automatic test_write_read();
        req = 2'b01; we = 2'b01; addr0 = 10'h155; wdata0 = 8'hA5;
        tick();  // arbitration edge
        req = 2'b00;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b want 01", gnt); end
        checks++; if ({mem_wr_en, mem_rd_en} !== 2'b10) begin errors++; $display("FAIL wr_en: got %b want 10", {mem_wr_en, mem_rd_en}); end
        checks++; if (mem_addr !== 10'h155) begin errors++; $display("FAIL wr_addr: got %h want 155", mem_addr); end
        checks++; if (mem_wdata !== 8'hA5) begin errors++; $display("FAIL wr_wdata: got %h want a5", mem_wdata); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy); end
        tick();
        checks++; if (ack !== 2'b01) begin errors++; $display("FAIL wr_ack: got %b want 01", ack); end
        checks++; if ({gnt, mem_wr_en, mem_rd_en} !== 4'b0000) begin errors++; $display("FAIL wr_done_bus: got %b want 0000", {gnt, mem_wr_en, mem_rd_en}); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata_hold: got %h want 00", rdata); end
        tick();
        checks++; if ({busy, ack} !== 3'b000) begin errors++; $display("FAIL wr_idle: got %b want 000", {busy, ack}); end
        req = 2'b01; we = 2'b00; wdata0 = 8'h00;
        tick();
        req = 2'b00;
        checks++; if ({mem_wr_en, mem_rd_en} !== 2'b01) begin errors++; $display("FAIL rd_en: got %b want 01", {mem_wr_en, mem_rd_en}); end
        checks++; if (mem_addr !== 10'h155) begin errors++; $display("FAIL rd_addr: got %h want 155", mem_addr); end
        tick();
        checks++; if (ack !== 2'b01) begin errors++; $display("FAIL rd_ack: got %b want 01", ack); end
        checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL rd_rdata: got %h want a5", rdata); end
        tick();
    endtask

    task automatic test_tie();
        logic [1:0]    exp_g;
        logic [DW-1:0] exp_d;
        reset_p = 1'b1; req = 2'b00;
        tick();
        reset_p = 1'b0;
        mem[10'h2AA] = 8'h3C;
        req = 2'b11; we = 2'b00; addr0 = 10'h155; addr1 = 10'h2AA;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (i % 2 == 0) ? 8'hA5 : 8'h3C;
            tick();
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL tie_gnt[%0d]: got %b want %b", i, gnt, exp_g); end
            tick();
            checks++; if (ack !== exp_g) begin errors++; $display("FAIL tie_ack[%0d]: got %b want %b", i, ack, exp_g); end
            checks++; if (rdata !== exp_d) begin errors++; $display("FAIL tie_rdata[%0d]: got %h want %h", i, rdata, exp_d); end
            tick();
        end
        req = 2'b00;
    endtask

    task automatic test_latency();
        req = 2'b10; we = 2'b00; addr1 = 10'h2AA;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL lat_pre_gnt: got %b want 00", gnt); end
        tick();  // edge k
        addr1 = 10'h001; req = 2'b00;
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL lat_gnt: got %b want 10", gnt); end
        checks++; if (mem_addr !== 10'h2AA) begin errors++; $display("FAIL lat_addr: got %h want 2aa", mem_addr); end
        tick();
        checks++; if (ack !== 2'b10) begin errors++; $display("FAIL lat_ack: got %b want 10", ack); end
        checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL lat_rdata: got %h want 3c", rdata); end
        tick();
        checks++; if ({busy, gnt, ack} !== 5'b0) begin errors++; $display("FAIL lat_idle: got %b want 00000", {busy, gnt, ack}); end
    endtask

    task automatic test_exclusivity();
        int acks = 0;
        int cyc = 0;
        while (acks < 1000 && cyc < 20000) begin
            req = 2'($urandom_range(0, 3)); we = 2'($urandom_range(0, 3));
            addr0 = AW'($urandom); addr1 = AW'($urandom);
            wdata0 = DW'($urandom); wdata1 = DW'($urandom);
            tick();
            cyc++;
            checks++; if ((mem_wr_en & mem_rd_en) !== 1'b0) begin errors++; $display("FAIL ex_both: cyc %0d wr=%b rd=%b", cyc, mem_wr_en, mem_rd_en); end
            checks++; if (!busy && (mem_wr_en | mem_rd_en) !== 1'b0) begin errors++; $display("FAIL ex_idle_en: cyc %0d got %b want 0", cyc, mem_wr_en | mem_rd_en); end
            checks++; if (gnt == 2'b00 && (mem_wr_en | mem_rd_en) !== 1'b0) begin errors++; $display("FAIL ex_noacc_en: cyc %0d got %b want 0", cyc, mem_wr_en | mem_rd_en); end
            checks++; if ($countones(gnt) > 1 || $countones(ack) > 1 || (gnt & ack) != 2'b00) begin errors++; $display("FAIL ex_onehot: cyc %0d gnt=%b ack=%b", cyc, gnt, ack); end
            if (ack != 2'b00) acks++;
        end
        req = 2'b00;
        checks++; if (acks < 1000) begin errors++; $display("FAIL ex_timeout: got %0d acks want 1000", acks); end
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        req = 2'b01; we = 2'b01; addr0 = 10'h3FF; wdata0 = 8'h77;
        tick();
        checks++; if ({gnt, mem_wr_en} !== 3'b011) begin errors++; $display("FAIL rm_access: got %b want 011", {gnt, mem_wr_en}); end
        reset_p = 1'b1; req = 2'b00;
        tick();
        reset_p = 1'b0;
        checks++; if ({gnt, ack, busy, mem_wr_en, mem_rd_en} !== 7'b0) begin errors++; $display("FAIL rm_ctrl: got %b want 0000000", {gnt, ack, busy, mem_wr_en, mem_rd_en}); end
        checks++; if ({mem_addr, mem_wdata, rdata} !== 26'b0) begin errors++; $display("FAIL rm_data: got %h want 0", {mem_addr, mem_wdata, rdata}); end
        tick();
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL rm_noack: got %b want 00", ack); end
        req = 2'b11; we = 2'b00; addr1 = 10'h2AA;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rm_tie_gnt: got %b want 01", gnt); end
        tick();
        checks++; if (ack !== 2'b01) begin errors++; $display("FAIL rm_ack: got %b want 01", ack); end
        tick();
        tick();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rm_next_gnt: got %b want 10", gnt); end
        req = 2'b00;
        tick(); tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        reset_p = 1'b1; req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        test_reset();
        test_write_read();
        test_tie();
        test_latency();
        test_exclusivity();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
